cpu_sequencer: RTL
==================

# cpu_sequencer

Multi-cycle sequencer that steps the core through fetch, decode, execute, memory and writeback for every instruction. It owns the opcode decode for LOAD (7'b0000000), ADDI (7'b0010011) and STORE (7'b1111111), and drives the ALU op, data-memory strobes, register-file write enable and PC/IR load enables. It also handshakes with instruction and data memory, supervises both with a wait-state timeout, and counts retired instructions.

## Interface
- TIMEOUT, 15: max consecutive not-ready cycles tolerated on any memory wait (range 1..255)
- CNT_W, 32: width of retired-instruction counter
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- imem_req  output  1  instruction fetch request
- imem_ready  input  1  fetch data valid this cycle
- imem_rdata  input  32  fetched instruction; opcode = bits [6:0]
- ir_en  output  1  load instruction register this cycle
- pc_en  output  1  advance PC this cycle
- alu_op  output  4  ALU operation
- dmem_read  output  1  data read request
- dmem_write  output  1  data write request
- dmem_ready  input  1  data access complete this cycle
- reg_write  output  1  register-file write enable
- state  output  3  current state, for debug
- halted  output  1  sequencer in HALT
- illegal  output  1  sticky: unknown opcode decoded
- bus_err  output  1  sticky: memory wait timed out
- retired  output  CNT_W  retired instruction count

## Operation
- States: FETCH=3'd0, DECODE=3'd1, EXEC=3'd2, MEM=3'd3, WB=3'd4, HALT=3'd7. Codes 5 and 6 are unused and return to FETCH.
- FETCH: imem_req=1.
  - On imem_ready, ir_en=1 (combinational, same cycle). imem_rdata[6:0] is latched into the internal opcode register. Next state is DECODE.
- DECODE: one cycle, no strobes.
  - Known opcode: go to EXEC.
  - Otherwise: set illegal and go to HALT.
- EXEC: one cycle. alu_op=4'b0000 (add) for all three opcodes. LOAD and STORE use it for address generation.
  - ADDI goes to WB. LOAD and STORE go to MEM.
- MEM: dmem_read=1 for LOAD, or dmem_write=1 for STORE, held until dmem_ready.
  - LOAD on ready: go to WB.
  - STORE on ready: pc_en=1 in the same cycle, retired increments, go to FETCH.
- WB: one cycle. reg_write=1, pc_en=1, retired increments, go to FETCH.
- HALT: all strobes 0, halted=1. Only rst_n leaves HALT.
- Outside EXEC, alu_op=4'b0000 and all strobes not listed for a state are 0.
- Wait timer (8-bit):
  - Cleared on every entry to FETCH or MEM.
  - Increments each cycle the relevant ready is low.
  - If ready is low and timer == TIMEOUT-1: set bus_err, go to HALT, no strobe effects.
  - Ready has priority over timeout. Ready arriving on the TIMEOUT-th wait cycle is accepted.
- retired wraps modulo 2^CNT_W and never saturates.
- illegal and bus_err are sticky until reset.

## Timing
- Reset (rst_n low at a clock edge):
  - state=FETCH, opcode reg=0, timer=0, retired=0, illegal=0, bus_err=0.
  - While rst_n is low, every output strobe (imem_req, ir_en, pc_en, dmem_read, dmem_write, reg_write) is forced to 0 and halted=0.
  - The first imem_req appears in the first cycle with rst_n high.
- Reset mid-instruction aborts it immediately. No pc_en, reg_write or retire is issued for the aborted instruction.
- Zero-wait latency, from the FETCH entry cycle to the return to FETCH:
  - ADDI: 4 cycles (F, D, E, WB).
  - LOAD: 5 cycles (F, D, E, M, WB).
  - STORE: 4 cycles (F, D, E, M).
- Each wait cycle in FETCH or MEM adds 1 cycle.
- Requests (imem_req, dmem_read/dmem_write) stay stable and asserted every cycle until the ready cycle. They drop in the cycle after ready.
- ir_en and pc_en are 1-cycle pulses. Exactly one pc_en and one retire occur per completed instruction.
- A ready input asserted outside its waiting state is ignored.

## Test plan
- Reset then ADDI (0x00000013), imem_ready and dmem_ready tied 1 -> state sequence 0,1,2,4,0; reg_write and pc_en high only in cycle 4; retired=1.
- LOAD (0x00000000) with dmem_ready asserted after 3 low cycles -> dmem_read high for 4 cycles; WB follows; reg_write 1 cycle; total 8 cycles; retired=1.
- STORE (0x0000007F), zero wait -> dmem_write 1 cycle with pc_en in the same cycle; reg_write never asserted; back in FETCH after 4 cycles.
- Opcode 0x33 fetched -> DECODE then HALT; illegal=1, halted=1; no pc_en; remains halted 20 cycles until rst_n low.
- TIMEOUT=15: imem_ready low 14 cycles then high -> accepted, no bus_err. Repeat with 15 low cycles -> bus_err=1, HALT on the cycle after the 15th.
- CNT_W=4: run 17 ADDIs -> retired=1 after wrap; then assert rst_n low during MEM of a LOAD -> retired=0, no reg_write, all strobes 0 during reset.

Source files
------------

// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: fetch/decode/execute/memory/writeback control with
// memory wait-state supervision and a retired-instruction counter.
module cpu_sequencer #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  output logic             imem_req_o,
  input  logic             imem_ready_i,
  input  logic [31:0]      imem_rdata_i,
  output logic             ir_en_o,
  output logic             pc_en_o,
  output logic [3:0]       alu_op_o,
  output logic             dmem_read_o,
  output logic             dmem_write_o,
  input  logic             dmem_ready_i,
  output logic             reg_write_o,
  output logic [2:0]       state_o,
  output logic             halted_o,
  output logic             illegal_o,
  output logic             bus_err_o,
  output logic [CNT_W-1:0] retired_o
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd7
  } state_e;

  localparam logic [6:0] OpLoad   = 7'b0000000;
  localparam logic [6:0] OpAddi   = 7'b0010011;
  localparam logic [6:0] OpStore  = 7'b1111111;
  localparam logic [3:0] AluAdd   = 4'b0000;
  localparam logic [7:0] TimerMax = 8'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [6:0]       opcode_q, opcode_d;
  logic [7:0]       timer_q, timer_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             illegal_q, illegal_d;
  logic             bus_err_q, bus_err_d;
  logic             retire;
  logic             is_load, is_store, is_known;
  logic             unused_rdata;

  assign unused_rdata = ^imem_rdata_i[31:7];
  assign is_load      = (opcode_q == OpLoad);
  assign is_store     = (opcode_q == OpStore);
  assign is_known     = opcode_q inside {OpLoad, OpAddi, OpStore};

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      opcode_q  <= '0;
      timer_q   <= '0;
      retired_q <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      opcode_q  <= opcode_d;
      timer_q   <= timer_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Timer only counts while stalled in FETCH/MEM, so it is zero on every entry to them.
  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    timer_d   = '0;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    retire    = 1'b0;
    case (state_q)
      StFetch: begin
        if (imem_ready_i) begin
          opcode_d = imem_rdata_i[6:0];
          state_d  = StDecode;
        end else if (timer_q == TimerMax) begin
          bus_err_d = 1'b1;
          state_d   = StHalt;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      StDecode: begin
        if (is_known) begin
          state_d = StExec;
        end else begin
          illegal_d = 1'b1;
          state_d   = StHalt;
        end
      end
      StExec: state_d = (opcode_q == OpAddi) ? StWb : StMem;
      StMem: begin
        if (dmem_ready_i) begin
          if (is_store) begin
            retire  = 1'b1;
            state_d = StFetch;
          end else begin
            state_d = StWb;
          end
        end else if (timer_q == TimerMax) begin
          bus_err_d = 1'b1;
          state_d   = StHalt;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      StWb: begin
        retire  = 1'b1;
        state_d = StFetch;
      end
      StHalt:  state_d = StHalt;
      default: state_d = StFetch;
    endcase
    retired_d = retired_q + CNT_W'(retire);
  end

  always_comb begin
    imem_req_o   = 1'b0;
    ir_en_o      = 1'b0;
    pc_en_o      = 1'b0;
    dmem_read_o  = 1'b0;
    dmem_write_o = 1'b0;
    reg_write_o  = 1'b0;
    halted_o     = 1'b0;
    alu_op_o     = AluAdd;
    if (rst_ni) begin
      case (state_q)
        StFetch: begin
          imem_req_o = 1'b1;
          ir_en_o    = imem_ready_i;
        end
        StMem: begin
          dmem_read_o  = is_load;
          dmem_write_o = is_store;
          pc_en_o      = is_store & dmem_ready_i;
        end
        StWb: begin
          reg_write_o = 1'b1;
          pc_en_o     = 1'b1;
        end
        StHalt:  halted_o = 1'b1;
        default: ;
      endcase
    end
  end

  assign state_o   = state_q;
  assign illegal_o = illegal_q;
  assign bus_err_o = bus_err_q;
  assign retired_o = retired_q;

endmodule
